// File: rtl/joy_pkg.sv
// rtl/joy_pkg.sv - scan states, button/pin indices and per-port sample step
// for the Sega pad scanner
package joy_pkg;

  typedef enum logic [2:0] {
    SEL_LO0 = 3'd0,
    SEL_HI0 = 3'd1,
    RD_BASE = 3'd2,
    RD_MD   = 3'd3,
    SEL_LO1 = 3'd4,
    DET6    = 3'd5,
    RD_EXT  = 3'd6,
    IDLE    = 3'd7
  } scan_state_e;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_B = 4;
  localparam int unsigned BTN_C = 5;
  localparam int unsigned BTN_A = 6;
  localparam int unsigned BTN_S = 7;
  localparam int unsigned BTN_Z = 8;
  localparam int unsigned BTN_Y = 9;
  localparam int unsigned BTN_X = 10;
  localparam int unsigned BTN_M = 11;

  localparam int unsigned PIN_UP    = 0;
  localparam int unsigned PIN_DOWN  = 1;
  localparam int unsigned PIN_LEFT  = 2;
  localparam int unsigned PIN_RIGHT = 3;
  localparam int unsigned PIN_P6    = 4;
  localparam int unsigned PIN_P9    = 5;

  localparam logic [11:0] JOY_RELEASED = 12'hFFF;

  typedef struct packed {
    logic [11:0] shadow;
    logic        det6;
  } port_scan_t;

  localparam port_scan_t PORT_RESET = {JOY_RELEASED, 1'b0};

  // What one port's shadow/det6 become on a tick in state st, given its synced pins.
  function automatic port_scan_t port_step(input scan_state_e st,
                                           input port_scan_t  cur,
                                           input logic [5:0]  pin);
    port_scan_t nxt;
    logic [3:0] dirs;
    nxt  = cur;
    dirs = pin[PIN_RIGHT:PIN_UP];
    case (st)
      RD_BASE: begin
        nxt.shadow[BTN_R:BTN_U] = dirs;
        nxt.shadow[BTN_C:BTN_B] = pin[PIN_P9:PIN_P6];
        nxt.det6                = 1'b0;
      end
      RD_MD: begin
        // L and R both low with select low only happens on a Mega Drive pad
        if (!pin[PIN_RIGHT] && !pin[PIN_LEFT]) begin
          nxt.shadow[BTN_S:BTN_A] = pin[PIN_P9:PIN_P6];
        end else begin
          nxt.shadow[BTN_S:BTN_A] = 2'b11;
          nxt.shadow[BTN_C:BTN_B] = pin[PIN_P9:PIN_P6];
        end
      end
      DET6: begin
        nxt.det6 = (dirs == 4'h0);
      end
      RD_EXT: begin
        nxt.shadow[BTN_M:BTN_Z] = cur.det6 ? dirs : 4'hF;
      end
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/joy_sega_scan_sync2.sv
// rtl/joy_sega_scan_sync2.sv - two-flop synchronizer for raw pad pins,
// resets to all-released
module sync2 #(
  parameter int unsigned W = 6
) (
  input  logic         clk_i,
  input  logic         res_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/joy_sega_scan.sv
// rtl/joy_sega_scan.sv - tick-paced select sequencer that reads two Sega
// 3/6-button or Master System pads and commits both ports atomically
module joy_sega_scan
  import joy_pkg::*;
#(
  parameter int unsigned IDLE_TICKS = 248
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        tick_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        sel_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  localparam logic [9:0] IDLE_LAST = 10'(IDLE_TICKS - 1);

  logic [5:0] j1, j2;

  sync2 #(.W(6)) u_sync1 (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .d_i     (joy1_i),
    .q_o     (j1)
  );

  sync2 #(.W(6)) u_sync2 (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .d_i     (joy2_i),
    .q_o     (j2)
  );

  scan_state_e state_q, state_d;
  logic [9:0]  idle_cnt_q, idle_cnt_d;
  logic        sel_q, sel_d;
  port_scan_t  p1_q, p1_d, p2_q, p2_d;
  port_scan_t  p1_step, p2_step;
  logic [11:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic        six1_q, six1_d, six2_q, six2_d;
  logic        frame_q, frame_d;

  always_comb begin
    p1_step    = port_step(state_q, p1_q, j1);
    p2_step    = port_step(state_q, p2_q, j2);
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    sel_d      = sel_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    joy1_d     = joy1_q;
    joy2_d     = joy2_q;
    six1_d     = six1_q;
    six2_d     = six2_q;
    frame_d    = 1'b0;

    if (tick_i) begin
      p1_d = p1_step;
      p2_d = p2_step;
      case (state_q)
        SEL_LO0: begin
          sel_d   = 1'b0;
          state_d = SEL_HI0;
        end
        SEL_HI0: begin
          sel_d   = 1'b1;
          state_d = RD_BASE;
        end
        RD_BASE: begin
          sel_d   = 1'b0;
          state_d = RD_MD;
        end
        RD_MD: begin
          sel_d   = 1'b1;
          state_d = SEL_LO1;
        end
        SEL_LO1: begin
          sel_d   = 1'b0;
          state_d = DET6;
        end
        DET6: begin
          sel_d   = 1'b1;
          state_d = RD_EXT;
        end
        RD_EXT: begin
          // Commit takes the step results so the extended nibble lands with the rest.
          sel_d   = 1'b0;
          state_d = IDLE;
          joy1_d  = p1_step.shadow;
          joy2_d  = p2_step.shadow;
          six1_d  = p1_step.det6;
          six2_d  = p2_step.det6;
          frame_d = 1'b1;
        end
        IDLE: begin
          sel_d = 1'b1;
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = '0;
            state_d    = SEL_LO0;
          end else begin
            idle_cnt_d = idle_cnt_q + 10'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      sel_q      <= 1'b1;
      p1_q       <= PORT_RESET;
      p2_q       <= PORT_RESET;
      joy1_q     <= JOY_RELEASED;
      joy2_q     <= JOY_RELEASED;
      six1_q     <= 1'b0;
      six2_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      sel_q      <= sel_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      six1_q     <= six1_d;
      six2_q     <= six2_d;
      frame_q    <= frame_d;
    end
  end

  assign sel_o   = sel_q;
  assign joy1_o  = joy1_q;
  assign joy2_o  = joy2_q;
  assign six1_o  = six1_q;
  assign six2_o  = six2_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_joy_sega_scan.sv
// tb/tb_joy_sega_scan.sv - pad models drive two ports; expected button words
// are queued per scan and checked when frame_o fires
module tb_joy_sega_scan;

  localparam int PAD_NONE   = 0;
  localparam int PAD_SMS    = 1;
  localparam int PAD_MD3    = 2;
  localparam int PAD_MD6    = 3;
  localparam int IDLE_T     = 248;
  localparam int SCAN_TICKS = IDLE_T + 7;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        tick = 1'b0;
  logic [5:0]  joy1_in = 6'h3F;
  logic [5:0]  joy2_in = 6'h3F;
  logic        sel_o, six1_o, six2_o, frame_o;
  logic [11:0] joy1_o, joy2_o;

  logic        sel2, six1b, six2b, frame2;
  logic [11:0] joy1b, joy2b;

  always #5 clk = ~clk;

  joy_sega_scan #(.IDLE_TICKS(IDLE_T)) dut (
    .clk_i   (clk),
    .res_n_i (res_n),
    .tick_i  (tick),
    .joy1_i  (joy1_in),
    .joy2_i  (joy2_in),
    .sel_o   (sel_o),
    .joy1_o  (joy1_o),
    .joy2_o  (joy2_o),
    .six1_o  (six1_o),
    .six2_o  (six2_o),
    .frame_o (frame_o)
  );

  joy_sega_scan #(.IDLE_TICKS(1)) dut_fast (
    .clk_i   (clk),
    .res_n_i (res_n),
    .tick_i  (1'b1),
    .joy1_i  (6'h3F),
    .joy2_i  (6'h3F),
    .sel_o   (sel2),
    .joy1_o  (joy1b),
    .joy2_o  (joy2b),
    .six1_o  (six1b),
    .six2_o  (six2b),
    .frame_o (frame2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;

  int          p1_type = PAD_NONE;
  int          p2_type = PAD_NONE;
  logic [11:0] p1_btn = 12'h000;
  logic [11:0] p2_btn = 12'h000;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic        s1;
    logic        s2;
    int          tick;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (tick %0d)", name, act, exp, tick_cnt);
    end
  endtask

  // Button masks are 1 = pressed, indexed U,D,L,R,B,C,A,S,Z,Y,X,M from bit 0.
  function automatic logic [11:0] exp_joy(input int typ, input logic [11:0] b);
    case (typ)
      PAD_SMS: return ~(b & 12'h03F);
      PAD_MD3: return ~(b & 12'h0FF);
      PAD_MD6: return ~b;
      default: return 12'hFFF;
    endcase
  endfunction

  // Pad pin model {p9,p6,right,left,down,up}; lows = select falling edges this scan.
  function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] b,
                                          input logic sel, input int lows);
    logic [5:0] p;
    case (typ)
      PAD_SMS: p = ~b[5:0];
      PAD_MD3, PAD_MD6: begin
        if (sel)
          p = (typ == PAD_MD6 && lows == 3) ? ~{b[5], b[4], b[11], b[10], b[9], b[8]} : ~b[5:0];
        else
          p = (typ == PAD_MD6 && lows == 3) ? {~b[7], ~b[6], 4'b0000}
                                            : {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
      end
      default: p = 6'h3F;
    endcase
    return p;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  logic sel_prev = 1'b1;
  int   lows = 0;
  int   quiet = 0;

  always @(posedge clk) begin
    #1;
    if (sel_o !== sel_prev) begin
      if (sel_o === 1'b0) lows++;
      quiet = 0;
    end else if (quiet < 1000) begin
      quiet++;
    end
    if (quiet > 64) lows = 0;
    sel_prev = sel_o;
    joy1_in  = pad_pins(p1_type, p1_btn, sel_o, lows);
    joy2_in  = pad_pins(p2_type, p2_btn, sel_o, lows);
  end

  always @(negedge clk) begin
    if (res_n === 1'b1 && frame_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: frame_o=1 at tick %0d, required no frame", tick_cnt);
      end else begin
        mon_e = sb.pop_front();
        chk("frame_tick", tick_cnt, mon_e.tick);
        chk("joy1_o", joy1_o, mon_e.j1);
        chk("joy2_o", joy2_o, mon_e.j2);
        chk("six1_o", six1_o, mon_e.s1);
        chk("six2_o", six2_o, mon_e.s2);
      end
    end
  end

  int gap2 = 0;
  int seen2 = 0;
  int nfr2 = 0;

  always @(negedge clk) begin
    if (res_n !== 1'b1) begin
      gap2  = 0;
      seen2 = 0;
      nfr2  = 0;
    end else begin
      gap2++;
      if (frame2 === 1'b1) begin
        if (nfr2 < 16) begin
          if (seen2 != 0) chk("fast_period", gap2, 8);
          chk("fast_joy", {joy1b, joy2b}, 24'hFFFFFF);
          chk("fast_six", {six1b, six2b}, 2'b00);
          chk("fast_sel", sel2, 1'b0);
        end
        seen2 = 1;
        gap2  = 0;
        nfr2++;
      end
    end
  end

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    tick_cnt++;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_scan(input int t1, input logic [11:0] b1, input int t2,
                          input logic [11:0] b2, input bit chk_sel, input bit chk_mid);
    exp_t e;
    logic [7:0] sel_pat;
    sel_pat = 8'b0101_0101;
    p1_type = t1;
    p1_btn  = b1;
    p2_type = t2;
    p2_btn  = b2;
    e.j1    = exp_joy(t1, b1);
    e.j2    = exp_joy(t2, b2);
    e.s1    = (t1 == PAD_MD6);
    e.s2    = (t2 == PAD_MD6);
    e.tick  = tick_cnt + SCAN_TICKS;
    sb.push_back(e);
    for (int i = 1; i <= SCAN_TICKS; i++) begin
      do_tick();
      if (chk_sel && i >= IDLE_T) chk("sel_seq", sel_o, sel_pat[i-IDLE_T]);
      if (chk_mid && i == 200) begin
        chk("mid_rst_joy1", joy1_o, 12'hFFF);
        chk("mid_rst_joy2", joy2_o, 12'hFFF);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0;
    tick  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel_o, 1'b1);
    chk("rst_joy1", joy1_o, 12'hFFF);
    chk("rst_joy2", joy2_o, 12'hFFF);
    chk("rst_six", {six1_o, six2_o}, 2'b00);
    chk("rst_frame", frame_o, 1'b0);
    res_n = 1'b1;

    run_scan(PAD_NONE, 12'h000, PAD_NONE, 12'h000, 1'b1, 1'b0);
    run_scan(PAD_MD3, 12'h040, PAD_NONE, 12'h000, 1'b0, 1'b0);
    run_scan(PAD_NONE, 12'h000, PAD_MD6, 12'h400, 1'b0, 1'b0);
    run_scan(PAD_SMS, 12'h018, PAD_NONE, 12'h000, 1'b0, 1'b0);
    repeat (16) run_scan(int'($urandom_range(3, 0)), rand_btn(),
                         int'($urandom_range(3, 0)), rand_btn(), 1'b0, 1'b0);

    // Abort a scan in RD_MD after B was sampled in RD_BASE.
    p1_type = PAD_MD3;
    p1_btn  = 12'h010;
    p2_type = PAD_MD6;
    p2_btn  = rand_btn();
    repeat (IDLE_T + 3) do_tick();
    res_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_joy1", joy1_o, 12'hFFF);
    chk("abort_joy2", joy2_o, 12'hFFF);
    chk("abort_six", {six1_o, six2_o}, 2'b00);
    chk("abort_sel", sel_o, 1'b1);
    res_n = 1'b1;
    run_scan(PAD_MD3, 12'h010, p2_type, p2_btn, 1'b0, 1'b1);

    repeat (2) run_scan(int'($urandom_range(3, 0)), rand_btn(),
                        int'($urandom_range(3, 0)), rand_btn(), 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("frames_pending", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/joy_sega_scan.md
JOY_SEGA_SCAN -- requirements
Module: joy_sega_scan

Interface
REQ-001 Parameter IDLE_TICKS, default 248, number of tick_i strobes spent in IDLE per scan; legal range 1..1023.
REQ-002 clk_i  in  1  system clock (clk_sys domain); single clock for the whole block.
REQ-003 res_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 tick_i  in  1  one-cycle scan-step strobe (typically once per video line); all state advances only on cycles with tick_i=1.
REQ-005 joy1_i  in  6  port-1 raw pins, active-low, {p9,p6,right,left,down,up}; asynchronous to clk_i.
REQ-006 joy2_i  in  6  port-2 raw pins, same format as joy1_i.
REQ-007 sel_o  out  1  shared select line driven to both ports (pin 7).
REQ-008 joy1_o  out  12  port-1 decoded buttons, active-low, {M,X,Y,Z,S,A,C,B,R,L,D,U}.
REQ-009 joy2_o  out  12  port-2 decoded buttons, same format.
REQ-010 six1_o, six2_o  out  1 each  port detected as 6-button pad in last completed scan.
REQ-011 frame_o  out  1  one-cycle pulse when joy1_o/joy2_o/six*_o are committed.

Function
REQ-012 joy1_i/joy2_i SHALL pass through a 2-flop synchronizer; all decisions below use synchronized values (j.U..j.p9).
REQ-013 FSM states in order: SEL_LO0, SEL_HI0, RD_BASE, RD_MD, SEL_LO1, DET6, RD_EXT, IDLE; each non-IDLE state lasts exactly one tick, then advances.
REQ-014 SEL_LO0 on tick: sel_o<=0. SEL_HI0 on tick: sel_o<=1.
REQ-015 RD_BASE on tick, per port: shadow[3:0]<={R,L,D,U}, shadow[5:4]<={p9,p6}, det6<=0, sel_o<=0.
REQ-016 RD_MD on tick, per port: if R=0 and L=0 then shadow[7:6]<={p9,p6}, else shadow[7:6]<=2'b11 and shadow[5:4]<={p9,p6}; sel_o<=1.
REQ-017 SEL_LO1 on tick: sel_o<=0.
REQ-018 DET6 on tick, per port: det6<=1 iff U,D,L,R all 0; sel_o<=1.
REQ-019 RD_EXT on tick, per port: shadow[11:8]<={R,L,D,U} if det6=1 else 4'hF; sel_o<=0; then commit.
REQ-020 Commit SHALL copy both shadows and det6 flags to joy*_o/six*_o in the same clock edge (atomic; outputs never show a partial scan), and frame_o SHALL be 1 on the following cycle only.
REQ-021 IDLE: sel_o<=1 on entry tick; idle counter counts tick_i; after IDLE_TICKS ticks in IDLE, next state SEL_LO0, counter cleared.
REQ-022 Full scan period = 7 + IDLE_TICKS ticks; counter width 10 bits, no wrap inside legal range.
REQ-023 tick_i=0 cycles SHALL hold all registers; tick_i held high advances one state per clock.
REQ-024 Ports are independent: detection on one port SHALL not affect the other's data or six flag.

Reset
REQ-025 While res_n_i=0: state=IDLE, idle counter=0, sel_o=1, joy1_o=joy2_o=12'hFFF, shadows=12'hFFF, six1_o=six2_o=0, det6=0, frame_o=0, synchronizer flops=6'h3F.
REQ-026 Reset asserted mid-scan SHALL discard the partial shadow; no commit or frame_o occurs for that scan.
REQ-027 After release, first SEL_LO0 occurs after IDLE_TICKS ticks.

Structure
REQ-028 Package joy_pkg SHALL hold the state enum, the 12-bit button index constants (U=0..M=11) and JOY_RELEASED=12'hFFF.
REQ-029 One sub-module, sync2, SHALL implement the 6-bit 2-flop synchronizer (instanced per port, async active-low reset to all-ones).

Verification
REQ-030 Reset, then 300 ticks with both ports idle (6'h3F) -> sel_o toggles 1,0,1,0,1,0 sequence per scan, joy*_o=12'hFFF, six*_o=0, frame_o once per 255 ticks.
REQ-031 Port 1 3-button model, A held (p6=0 when sel=0, L/R=0 when sel=0) -> joy1_o=12'hFBF (A=0), six1_o=0, joy2_o=12'hFFF.
REQ-032 Port 2 6-button model, X held (all dirs 0 on third low, left=0 on third high) -> six2_o=1, joy2_o bit10=0, others 1.
REQ-033 Master System pad on port 1, button 1 and right held (L/R not both 0 with sel=0) -> joy1_o[7:6]=2'b11, bit4=0, bit3=0.
REQ-034 Reset pulse during RD_MD after B pressed in RD_BASE -> outputs stay 12'hFFF, no frame_o until next full scan.
REQ-035 tick_i held high continuously, IDLE_TICKS=1 -> scan completes every 8 clocks, frame_o period 8, outputs never change between commits.
